// File: rtl/master_valid_ready_tx.sv
// Transmit end of an 8-bit valid/ready link: FIFO-buffered producer bytes driven out as m_valid/m_data.
// Latency: byte pushed at edge E is presented on the link from edge E+1 when the output stage is idle or draining.
// Backpressure: s_ready=0 holds the output beat; in_ready drops once the FIFO is full (DEPTH+1 bytes held in total).
module master_valid_ready_tx #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  parameter  int CNT_W  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic              aclk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              s_ready,
  output logic [CNT_W-1:0]  xfer_count,
  output logic [LW-1:0]     fifo_level
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;

  // Output stage
  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic push;
  logic pop;
  logic fifo_empty;
  logic fifo_full;
  logic xfer;

  // in_ready looks only at the registered level (and reset), so a pop in the
  // same cycle never opens a slot early and there is no path from s_ready.
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LW'(DEPTH));
  assign in_ready   = !fifo_full && rstn;
  assign push       = in_valid && in_ready;

  // m_valid comes straight from the state register.
  assign m_valid    = (state_q == SEND);
  assign m_data     = data_q;
  assign xfer       = m_valid && s_ready;
  assign xfer_count = cnt_q;
  assign fifo_level = level_q;

  // Output-stage next state: decide when to pull the FIFO head into the output register.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // The beat on the link only moves once the slave has taken it.
        if (s_ready) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state: output register, pointers, occupancy and transfer counter.
  always_comb begin
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;

    if (pop) begin
      data_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    // Simultaneous push and pop leave the level unchanged.
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Counter wraps naturally at 2^CNT_W.
    if (xfer) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Control and output registers with synchronous active-low reset; reset discards buffered data.
  always_ff @(posedge aclk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array write; contents need no reset since occupancy gates every read.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_master_valid_ready_tx.sv
// Bench for master_valid_ready_tx: queue-level reference model compared every cycle,
// a handshake scoreboard, and directed scenarios with literal expectations.
// A second instance with a 4-bit counter exercises counter wrap on the same stimulus.
module tb_master_valid_ready_tx;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              aclk;
  logic              rstn;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              s_ready;

  logic              in_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [15:0]       xfer_count;
  logic [LW-1:0]     fifo_level;

  logic              in_ready4;
  logic              m_valid4;
  logic [DATA_W-1:0] m_data4;
  logic [3:0]        xfer_count4;
  logic [LW-1:0]     fifo_level4;

  int total;
  int bad;

  master_valid_ready_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .aclk       (aclk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .s_ready    (s_ready),
    .xfer_count (xfer_count),
    .fifo_level (fifo_level)
  );

  master_valid_ready_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
    .aclk       (aclk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready4),
    .m_valid    (m_valid4),
    .m_data     (m_data4),
    .s_ready    (s_ready),
    .xfer_count (xfer_count4),
    .fifo_level (fifo_level4)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The block is a queue of accepted bytes plus one presented beat; the
  // presented beat is replaced whenever it is absent or has just been taken.
  logic [7:0]  mq[$];
  bit          mv;
  logic [7:0]  md;
  int unsigned mcnt;
  bit          started;
  bit          m_acc;

  initial begin
    mv = 0; md = 8'h00; mcnt = 0; started = 0;
  end

  always @(posedge aclk) begin
    if (!rstn) begin
      mq.delete();
      mv = 0;
      md = 8'h00;
      mcnt = 0;
      started = 1;
    end else begin
      m_acc = in_valid && (mq.size() != DEPTH);
      if (mv && s_ready) mcnt++;
      if (!mv || s_ready) begin
        if (mq.size() > 0) begin
          md = mq.pop_front();
          mv = 1;
        end else begin
          mv = 0;
        end
      end
      if (m_acc) mq.push_back(in_data);
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  logic [7:0] sbq[$];
  bit         hold_pend;
  logic [7:0] hold_dat;
  logic [7:0] sb_exp;

  initial hold_pend = 0;

  always @(negedge aclk) begin
    if (started) begin
      check("m_valid",     {31'd0, m_valid}, {31'd0, mv});
      check("m_data",      {24'd0, m_data}, {24'd0, md});
      check("in_ready",    {31'd0, in_ready}, {31'd0, (rstn && (mq.size() != DEPTH))});
      check("fifo_level",  {29'd0, fifo_level}, mq.size());
      check("xfer_count",  {16'd0, xfer_count}, mcnt & 32'hFFFF);
      check("xfer_count4", {28'd0, xfer_count4}, mcnt & 32'hF);
      check("m_data4",     {24'd0, m_data4}, {24'd0, md});

      // A stalled beat must still be there, unchanged, one cycle later.
      if (hold_pend) begin
        check("hold_valid", {31'd0, m_valid}, 32'd1);
        check("hold_data",  {24'd0, m_data}, {24'd0, hold_dat});
      end
      hold_pend = m_valid && !s_ready && rstn;
      hold_dat  = m_data;

      // Handshake scoreboard: bytes leave in the order they were accepted.
      if (!rstn) begin
        sbq.delete();
      end else begin
        if (m_valid && s_ready) begin
          check("sb_nonempty", {31'd0, (sbq.size() > 0)}, 32'd1);
          if (sbq.size() > 0) begin
            sb_exp = sbq.pop_front();
            check("sb_order", {24'd0, m_data}, {24'd0, sb_exp});
          end
        end
        if (in_valid && in_ready) sbq.push_back(in_data);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rstn = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    s_ready = 1'b0;

    // Reset values
    step(); step(); step();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_xfer", {16'd0, xfer_count}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rstn = 1'b1;
    #1;
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Single beat
    s_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    check("sb1_level", {29'd0, fifo_level}, 32'd1);
    check("sb1_mvalid0", {31'd0, m_valid}, 32'd0);
    step();
    check("sb1_mvalid", {31'd0, m_valid}, 32'd1);
    check("sb1_mdata", {24'd0, m_data}, 32'hA5);
    step();
    check("sb1_mvalid_end", {31'd0, m_valid}, 32'd0);
    check("sb1_xfer", {16'd0, xfer_count}, 32'd1);

    // Streaming 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
      check("str_level", {29'd0, fifo_level}, 32'd1);
      if (i == 1) begin
        check("str_mvalid_first", {31'd0, m_valid}, 32'd0);
      end else begin
        check("str_mvalid", {31'd0, m_valid}, 32'd1);
        check("str_mdata", {24'd0, m_data}, 32'(i - 1));
      end
    end
    in_valid = 1'b0;
    step();
    check("str_last", {24'd0, m_data}, 32'h10);
    check("str_last_valid", {31'd0, m_valid}, 32'd1);
    step();
    check("str_idle", {31'd0, m_valid}, 32'd0);
    check("str_xfer", {16'd0, xfer_count}, 32'd17);

    // Backpressure hold
    s_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_data = 8'(8'h11 + k);
      step();
    end
    check("bp_full", {31'd0, in_ready}, 32'd0);
    check("bp_level", {29'd0, fifo_level}, 32'd4);
    check("bp_head", {24'd0, m_data}, 32'h11);
    in_data = 8'h99;
    step(); step();
    check("bp_head_stable", {24'd0, m_data}, 32'h11);
    check("bp_level_stable", {29'd0, fifo_level}, 32'd4);
    in_valid = 1'b0;
    s_ready = 1'b1;
    step();
    check("bp_recover", {31'd0, in_ready}, 32'd1);
    check("bp_d12", {24'd0, m_data}, 32'h12);
    check("bp_level3", {29'd0, fifo_level}, 32'd3);
    step(); check("bp_d13", {24'd0, m_data}, 32'h13);
    step(); check("bp_d14", {24'd0, m_data}, 32'h14);
    step(); check("bp_d15", {24'd0, m_data}, 32'h15);
    step();
    check("bp_idle", {31'd0, m_valid}, 32'd0);
    check("bp_xfer", {16'd0, xfer_count}, 32'd22);

    // Reset mid-operation
    s_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'(8'h21 + k);
      step();
    end
    check("mr_level", {29'd0, fifo_level}, 32'd3);
    check("mr_mvalid", {31'd0, m_valid}, 32'd1);
    rstn = 1'b0;
    in_valid = 1'b0;
    step();
    check("mr_rst_mvalid", {31'd0, m_valid}, 32'd0);
    check("mr_rst_mdata", {24'd0, m_data}, 32'd0);
    check("mr_rst_level", {29'd0, fifo_level}, 32'd0);
    check("mr_rst_xfer", {16'd0, xfer_count}, 32'd0);
    check("mr_rst_in_ready", {31'd0, in_ready}, 32'd0);
    rstn = 1'b1;
    s_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h7E;
    step();
    in_valid = 1'b0;
    check("mr_push_mvalid", {31'd0, m_valid}, 32'd0);
    step();
    check("mr_first_valid", {31'd0, m_valid}, 32'd1);
    check("mr_first_data", {24'd0, m_data}, 32'h7E);
    step();
    check("mr_done", {31'd0, m_valid}, 32'd0);
    check("mr_xfer", {16'd0, xfer_count}, 32'd1);

    // Counter wrap on the 4-bit instance: 17 transfers
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int j = 1; j <= 19; j++) begin
      in_valid = (j <= 17);
      in_data = 8'(8'h30 + j);
      step();
      if (j == 17) check("wrap_15", {28'd0, xfer_count4}, 32'd15);
      if (j == 18) check("wrap_0", {28'd0, xfer_count4}, 32'd0);
      if (j == 19) check("wrap_1", {28'd0, xfer_count4}, 32'd1);
    end
    check("wrap_wide", {16'd0, xfer_count}, 32'd17);
    check("wrap_idle", {31'd0, m_valid}, 32'd0);

    // Random stall
    for (int c = 0; c < 1000; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = 8'($urandom_range(0, 255));
      s_ready  = ($urandom_range(0, 9) < 6);
      step();
    end
    in_valid = 1'b0;
    s_ready = 1'b1;
    for (int c = 0; c < 12; c++) step();
    check("rnd_drained", sbq.size(), 32'd0);
    check("rnd_idle", {31'd0, m_valid}, 32'd0);
    check("rnd_level", {29'd0, fifo_level}, 32'd0);

    @(negedge aclk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
